wb_z80_bus_master: RTL and testbench
====================================

// Module: wb_z80_bus_master
// PURPOSE
//  Wishbone B4 classic slave that replays each accepted transfer as a Z80-style
//  bus cycle (nMREQ/nIORQ, nRD/nWR, nWAIT) toward legacy 8-bit peripherals.
//  Mirror of the CPU-side Z80->Wishbone bridge: fabric initiates, Z80 bus responds.
//  Split data bus (D_o/D_i/D_oe); the top-level pad ring builds the tristate.
// PARAMETERS
//  IO_PAGE      8'h01  wb_adr_i[23:16] value selecting an I/O cycle; any other value selects a memory cycle
//  SETUP_CYC    1      CLK cycles that A (and D_o for writes) are driven before strobes fall (>=1)
//  STROBE_CYC   3      minimum CLK cycles strobes are held low (>=3, covers nWAIT sync)
//  HOLD_CYC     1      CLK cycles that A/D_o are held after strobes rise (>=1)
//  WAIT_TMO     255    max extra strobe cycles while nWAIT is low before bus error (8-bit counter)
// PORTS
//  CLK        in   1   system clock
//  nRESET     in   1   reset; asynchronous, active-high
//  wb_cyc_i   in   1   Wishbone cycle
//  wb_stb_i   in   1   Wishbone strobe
//  wb_we_i    in   1   1 = write
//  wb_adr_i   in   24  [23:16] space select, [15:0] Z80 address
//  wb_dat_i   in   8   write data
//  wb_sel_i   in   1   byte select
//  wb_dat_o   out  8   read data
//  wb_ack_o   out  1   normal termination, one-cycle pulse
//  wb_err_o   out  1   error termination (nWAIT timeout), one-cycle pulse
//  A          out  16  Z80 address bus
//  D_o        out  8   data driven to the bus
//  D_oe       out  1   1 = drive D_o onto the pads
//  D_i        in   8   data from the pads
//  nMREQ      out  1   memory request, active-low
//  nIORQ      out  1   I/O request, active-low
//  nRD        out  1   read strobe, active-low
//  nWR        out  1   write strobe, active-low
//  nWAIT      in   1   asynchronous wait from the peripheral, active-low; 2-flop synchronised
//  busy       out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset (async): nMREQ=nIORQ=nRD=nWR=1, A=0, D_o=0, D_oe=0, wb_dat_o=0, ack=err=0, busy=0, FSM=IDLE.
//   Both nWAIT sync flops reset to 1.
//  FSM: IDLE -> SETUP -> STROBE -> HOLD -> TERM -> IDLE.
//  IDLE: on cyc&stb&sel, latch we/adr/dat, drive A=adr[15:0], go SETUP. If cyc&stb&!sel: no bus
//   cycle; go TERM, wb_dat_o=8'hFF, terminate with ack.
//  SETUP: SETUP_CYC cycles with strobes high. Write: D_o=data, D_oe=1 from the SETUP entry edge.
//  STROBE: nMREQ (mem) or nIORQ (I/O) low together with nRD (read) or nWR (write) for >= STROBE_CYC cycles.
//   After the minimum, extend while synchronised nWAIT=0 and increment the wait counter.
//   Counter == WAIT_TMO -> set err flag and leave.
//   On the exit edge, read captures D_i into wb_dat_o (err: wb_dat_o=8'hFF). All strobes rise on that same edge.
//  HOLD: HOLD_CYC cycles; A and D_o/D_oe unchanged.
//  TERM: one cycle, wb_ack_o=1 (or wb_err_o=1). D_oe=0 and A keeps its last value.
//   Next request is accepted in IDLE no earlier than the following edge.
//  Latency with no waits (defaults): termination pulse SETUP+STROBE+HOLD+1 = 6 cycles after the accept edge.
//  Never both strobes; never nRD and nWR together; strobes never fall in the same cycle A changes.
//  cyc_i dropped mid-transfer: the bus cycle runs to completion (no strobe truncation), ack/err
//   suppressed, return to IDLE.
//  stb_i during a busy transfer is ignored until IDLE.
//  nRESET mid-STROBE: strobes rise and D_oe=0 immediately (async); no termination is issued.
// TESTING
//  Mem write adr=24'h00_1234 dat=8'hA5, nWAIT=1 -> A=16'h1234, nMREQ&nWR low 3 cyc, D_oe=1 SETUP..HOLD, ack 6 cyc after accept, nIORQ=1 throughout.
//  I/O read adr=24'h01_00FE, D_i=8'h3C -> nIORQ&nRD low 3 cyc, wb_dat_o=8'h3C with ack, nMREQ=1 throughout.
//  Mem read, nWAIT low for 5 cycles from STROBE start -> strobe width = 3 + extension; ack latency grows to match; data correct.
//  nWAIT stuck low -> strobes rise after 3 + 255 strobe cycles, wb_err_o pulse, wb_dat_o=8'hFF, ack never asserted.
//  Write with sel=0 -> no strobe activity, ack 1 cycle after accept; cyc drop mid-STROBE -> full strobe width, no ack.
//  Async reset asserted mid-STROBE -> all strobes=1, D_oe=0 in the same cycle; after release, back-to-back read then write both complete.

Source files
------------

// File: rtl/wb_z80_bus_master.sv
// Wishbone B4 classic slave that replays each accepted transfer as a Z80-style
// bus cycle (nMREQ/nIORQ, nRD/nWR, nWAIT) toward legacy 8-bit peripherals.
module wb_z80_bus_master #(
    parameter logic [7:0]  IO_PAGE    = 8'h01,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 3,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned WAIT_TMO   = 255
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [23:0] wb_adr_i,
    input  logic [7:0]  wb_dat_i,
    input  logic        wb_sel_i,
    output logic [7:0]  wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [15:0] A,
    output logic [7:0]  D_o,
    output logic        D_oe,
    input  logic [7:0]  D_i,
    output logic        nMREQ,
    output logic        nIORQ,
    output logic        nRD,
    output logic        nWR,
    input  logic        nWAIT,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_TERM
    } state_t;

    localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);
    localparam logic [7:0] WAIT_LIMIT  = 8'(WAIT_TMO);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        we_q, we_d;
    logic        io_q, io_d;
    logic        err_q, err_d;
    logic        abort_q, abort_d;
    logic [15:0] a_d;
    logic [7:0]  do_d;
    logic        doe_d;
    logic [7:0]  rdat_d;
    logic        mreq_n_d, iorq_n_d, rd_n_d, wr_n_d;
    logic        strobe_on;
    logic        leave;
    logic        wait_s1, wait_s2;

    // nWAIT comes straight from a peripheral pin; idle level is released (1).
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge nRESET) begin
        if (nRESET) begin
            wait_s1 <= 1'b1;
            wait_s2 <= 1'b1;
        end else begin
            wait_s1 <= nWAIT;
            wait_s2 <= wait_s1;
        end
    end

    always_ff @(posedge CLK or posedge nRESET) begin
        if (nRESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wait_cnt_q <= '0;
            we_q       <= 1'b0;
            io_q       <= 1'b0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
            A          <= '0;
            D_o        <= '0;
            D_oe       <= 1'b0;
            wb_dat_o   <= '0;
            nMREQ      <= 1'b1;
            nIORQ      <= 1'b1;
            nRD        <= 1'b1;
            nWR        <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wait_cnt_q <= wait_cnt_d;
            we_q       <= we_d;
            io_q       <= io_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
            A          <= a_d;
            D_o        <= do_d;
            D_oe       <= doe_d;
            wb_dat_o   <= rdat_d;
            nMREQ      <= mreq_n_d;
            nIORQ      <= iorq_n_d;
            nRD        <= rd_n_d;
            nWR        <= wr_n_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wait_cnt_d = wait_cnt_q;
        we_d       = we_q;
        io_d       = io_q;
        err_d      = err_q;
        abort_d    = abort_q;
        a_d        = A;
        do_d       = D_o;
        doe_d      = D_oe;
        rdat_d     = wb_dat_o;
        leave      = 1'b0;

        // A master that drops cyc loses its termination, but the Z80 cycle still completes.
        if (state_q != ST_IDLE && !wb_cyc_i) begin
            abort_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    abort_d    = 1'b0;
                    err_d      = 1'b0;
                    cnt_d      = '0;
                    wait_cnt_d = '0;
                    if (wb_sel_i) begin
                        we_d  = wb_we_i;
                        io_d  = (wb_adr_i[23:16] == IO_PAGE);
                        a_d   = wb_adr_i[15:0];
                        if (wb_we_i) begin
                            do_d  = wb_dat_i;
                            doe_d = 1'b1;
                        end
                        state_d = ST_SETUP;
                    end else begin
                        rdat_d  = 8'hFF;
                        state_d = ST_TERM;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q != STROBE_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (!wait_s2) begin
                    if (wait_cnt_q == WAIT_LIMIT) begin
                        err_d = 1'b1;
                        leave = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    leave = 1'b1;
                end
                if (leave) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                    if (err_d) begin
                        rdat_d = 8'hFF;
                    end else if (!we_q) begin
                        rdat_d = D_i;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    doe_d   = 1'b0;
                    state_d = ST_TERM;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_TERM: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are registered and only enabled while the next state is STROBE,
        // so they fall one edge after A settles and rise on the exit edge.
        strobe_on = (state_d == ST_STROBE);
        mreq_n_d  = ~(strobe_on & ~io_q);
        iorq_n_d  = ~(strobe_on &  io_q);
        rd_n_d    = ~(strobe_on & ~we_q);
        wr_n_d    = ~(strobe_on &  we_q);
    end

    assign busy     = (state_q != ST_IDLE);
    assign wb_ack_o = (state_q == ST_TERM) && !err_q && !abort_q && wb_cyc_i;
    assign wb_err_o = (state_q == ST_TERM) &&  err_q && !abort_q && wb_cyc_i;

endmodule

// File: tb/tb_wb_z80_bus_master.sv
// Self-checking bench for wb_z80_bus_master: directed and randomized transfers
// checked against a cycle-count model of the Z80 bus protocol.
module tb_wb_z80_bus_master;

    localparam logic [7:0] IO_PAGE    = 8'h01;
    localparam int         SETUP_CYC  = 1;
    localparam int         STROBE_CYC = 3;
    localparam int         HOLD_CYC   = 1;
    localparam int         WAIT_TMO   = 255;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b1;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0, wb_sel_i = 1'b0;
    logic [23:0] wb_adr_i = '0;
    logic [7:0]  wb_dat_i = '0;
    logic [7:0]  wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic [15:0] A;
    logic [7:0]  D_o, D_i = '0;
    logic        D_oe;
    logic        nMREQ, nIORQ, nRD, nWR;
    logic        nWAIT = 1'b1;
    logic        busy;

    int checks = 0;
    int errors = 0;

    wb_z80_bus_master #(
        .IO_PAGE(IO_PAGE), .SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC),
        .HOLD_CYC(HOLD_CYC), .WAIT_TMO(WAIT_TMO)
    ) dut (
        .CLK(CLK), .nRESET(nRESET),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .A(A), .D_o(D_o), .D_oe(D_oe), .D_i(D_i),
        .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
        .nWAIT(nWAIT), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One Wishbone transfer. n_low = cycles nWAIT is held low starting when the
    // strobes are first seen low; stuck = nWAIT never released; drop_cyc = master
    // abandons the cycle as soon as the strobes are seen low.
    task automatic xfer(input string tag, input logic we, input logic sel,
                        input logic [23:0] adr, input logic [7:0] dat, input logic [7:0] di,
                        input int n_low, input bit stuck, input bit drop_cyc);
        bit          is_io, exp_err;
        int          ext, exp_width, exp_lat, exp_doe;
        int          c_mreq, c_iorq, c_rd, c_wr, c_doe, viol, low_cnt, lat;
        bit          strobe_seen, term_seen, done, any_low, prev_any;
        logic        ack_s, err_s;
        logic [7:0]  rdat_s;
        logic [15:0] prev_a;

        // Reference model: pure cycle arithmetic from the protocol rules.
        is_io     = (adr[23:16] == IO_PAGE);
        ext       = stuck ? WAIT_TMO : n_low;
        exp_err   = sel && stuck;
        exp_width = sel ? STROBE_CYC + ext : 0;
        exp_lat   = sel ? SETUP_CYC + exp_width + HOLD_CYC + 1 : 1;
        exp_doe   = (sel && we) ? SETUP_CYC + exp_width + HOLD_CYC : 0;

        c_mreq = 0; c_iorq = 0; c_rd = 0; c_wr = 0; c_doe = 0; viol = 0;
        low_cnt = 0; lat = 0; strobe_seen = 0; term_seen = 0; done = 0; prev_any = 0;
        ack_s = 0; err_s = 0; rdat_s = '0;

        @(negedge CLK);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr;
        wb_dat_i = dat; wb_sel_i = sel; D_i = di;
        prev_a = A;
        @(posedge CLK);
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge CLK);
            any_low = !nMREQ || !nIORQ || !nRD || !nWR;
            if (!nMREQ) c_mreq++;
            if (!nIORQ) c_iorq++;
            if (!nRD)   c_rd++;
            if (!nWR)   c_wr++;
            if (!nMREQ && !nIORQ) viol++;
            if (!nRD && !nWR) viol++;
            if (any_low && A !== adr[15:0]) viol++;
            if (any_low && !prev_any && A !== prev_a) viol++;
            if (D_oe) begin
                c_doe++;
                if (D_o !== dat) viol++;
            end
            prev_a   = A;
            prev_any = any_low;

            if (any_low && !strobe_seen) begin
                strobe_seen = 1;
                if (stuck || n_low > 0) begin
                    nWAIT   = 1'b0;
                    low_cnt = 1;
                end
                if (drop_cyc) begin
                    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
                end
            end else if (!nWAIT && !stuck) begin
                if (low_cnt == n_low) nWAIT = 1'b1;
                else low_cnt++;
            end

            if ((wb_ack_o || wb_err_o) && !term_seen) begin
                term_seen = 1;
                lat    = k + 1;
                ack_s  = wb_ack_o;
                err_s  = wb_err_o;
                rdat_s = wb_dat_o;
            end
            if (term_seen && !drop_cyc) begin
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0; nWAIT = 1'b1;
                done = 1;
            end
            if (drop_cyc && strobe_seen && !busy) done = 1;
        end
        nWAIT = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;

        check({tag, ".done"}, 32'(done), 32'd1);
        if (drop_cyc) begin
            check({tag, ".no_term"}, 32'(term_seen), 32'd0);
        end else begin
            check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
            check({tag, ".ack"}, 32'(ack_s), 32'(!exp_err));
            check({tag, ".err"}, 32'(err_s), 32'(exp_err));
            if (!we || !sel || exp_err) check({tag, ".rdata"}, 32'(rdat_s), exp_err || !sel ? 32'hFF : 32'(di));
        end
        check({tag, ".mreq_w"}, 32'(c_mreq), 32'(is_io ? 0 : exp_width));
        check({tag, ".iorq_w"}, 32'(c_iorq), 32'(is_io ? exp_width : 0));
        check({tag, ".rd_w"},   32'(c_rd),   32'(we ? 0 : exp_width));
        check({tag, ".wr_w"},   32'(c_wr),   32'(we ? exp_width : 0));
        check({tag, ".doe_w"},  32'(c_doe),  32'(exp_doe));
        check({tag, ".viol"},   32'(viol),   32'd0);
        @(negedge CLK);
        check({tag, ".idle"}, {29'd0, busy, wb_ack_o, wb_err_o}, 32'd0);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge CLK);
        check("rst.strobes", {28'd0, nMREQ, nIORQ, nRD, nWR}, 32'hF);
        check("rst.bus", {A, D_o, 7'd0, D_oe}, 32'd0);
        check("rst.wb", {21'd0, wb_dat_o, wb_ack_o, wb_err_o, busy}, 32'd0);
        nRESET = 1'b0;
        repeat (2) @(negedge CLK);

        // Directed cases.
        xfer("mem_wr",   1'b1, 1'b1, 24'h00_1234, 8'hA5, 8'h00, 0, 0, 0);
        xfer("io_rd",    1'b0, 1'b1, 24'h01_00FE, 8'h00, 8'h3C, 0, 0, 0);
        xfer("wait5_rd", 1'b0, 1'b1, 24'h00_8000, 8'h00, 8'h96, 5, 0, 0);
        xfer("tmo_rd",   1'b0, 1'b1, 24'h00_2222, 8'h00, 8'h11, 0, 1, 0);
        xfer("nosel_wr", 1'b1, 1'b0, 24'h00_5555, 8'h77, 8'h00, 0, 0, 0);
        xfer("cyc_drop", 1'b1, 1'b1, 24'h00_0ABC, 8'hC3, 8'h00, 0, 0, 1);
        xfer("io_wr",    1'b1, 1'b1, 24'h01_0010, 8'h42, 8'h00, 2, 0, 0);

        // Async reset in the middle of a write strobe.
        @(negedge CLK);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 1'b1;
        wb_adr_i = 24'h00_4321; wb_dat_i = 8'h5A;
        for (int k = 0; k < 10 && nWR; k++) @(negedge CLK);
        check("arst.pre_wr", 32'(nWR), 32'd0);
        check("arst.pre_doe", 32'(D_oe), 32'd1);
        #2 nRESET = 1'b1;
        #1;
        check("arst.strobes", {28'd0, nMREQ, nIORQ, nRD, nWR}, 32'hF);
        check("arst.doe_busy", {30'd0, D_oe, busy}, 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge CLK);
        check("arst.no_term", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
        nRESET = 1'b0;
        xfer("post_rd", 1'b0, 1'b1, 24'h00_3456, 8'h00, 8'hE7, 0, 0, 0);
        xfer("post_wr", 1'b1, 1'b1, 24'h00_3457, 8'h19, 8'h00, 0, 0, 0);

        // Randomized transfers.
        for (int i = 0; i < 16; i++) begin
            logic        r_we, r_sel;
            logic [23:0] r_adr;
            r_we  = 1'($urandom_range(0, 1));
            r_sel = ($urandom_range(0, 7) != 0);
            r_adr = {($urandom_range(0, 1) != 0) ? IO_PAGE : 8'($urandom), 16'($urandom)};
            xfer($sformatf("rnd%0d", i), r_we, r_sel, r_adr, 8'($urandom), 8'($urandom),
                 int'($urandom_range(0, 10)), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
